// File: rtl/nonogram_pkg.sv
// Shared types and sizing for the nonogram clue stream parser.
// Board limits, derived field widths, the packed line word layout and the
// parser state encoding live here so the parser and its users agree on them.
package nonogram_pkg;

    localparam int MAX_DIM   = 16;
    localparam int MAX_CLUES = 8;

    localparam int CLUE_W  = $clog2(MAX_DIM + 1);
    localparam int COUNT_W = $clog2(MAX_CLUES + 1);
    localparam int LINE_W  = COUNT_W + MAX_CLUES * CLUE_W;
    localparam int ADDR_W  = $clog2(2 * MAX_DIM);

    // Width used for dimension/line arithmetic so sums never wrap.
    localparam int CMP_W = CLUE_W + 1;
    // Width of a clue slot index.
    localparam int IDX_W = $clog2(MAX_CLUES);

    localparam logic [7:0] SYNC_BYTE = 8'hFF;

    // clue[0] is the leftmost/topmost clue and sits in the LSBs.
    typedef struct packed {
        logic [COUNT_W-1:0]                count;
        logic [MAX_CLUES-1:0][CLUE_W-1:0]  clue;
    } line_word_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GET_COLS  = 3'd1,
        GET_COUNT = 3'd2,
        GET_CLUE  = 3'd3,
        ERROR     = 3'd4
    } parser_state_t;

endpackage

// File: rtl/clue_stream_parser.sv
// Nonogram clue stream parser.
// Turns the uart byte stream (R, C, then R+C lines of "k clue..clue") into one
// packed clue word per line with its BRAM address, pulses board_done after the
// last line, and flags malformed input on a sticky err until a 0xFF sync byte.
// Optional build macro: CLUE_SUM_CHECK_EN adds a per-line check that the clues
// plus their mandatory one-cell gaps fit in the line length.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for the row-count header byte
// GET_COLS  | waiting for the column-count header byte
// GET_COUNT | waiting for the clue count of the current line
// GET_CLUE  | collecting clue bytes of the current line
// ERROR     | malformed stream seen; ignoring bytes until 0xFF
module clue_stream_parser
    import nonogram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              axiiv,
    input  logic [7:0]        axiid,
    output logic              axiov,
    output logic [LINE_W-1:0] axiod,
    output logic [ADDR_W-1:0] addr,
    output logic              board_done,
    output logic [CLUE_W-1:0] rows,
    output logic [CLUE_W-1:0] cols,
    output logic              err
);

    parser_state_t                    state;
    logic [ADDR_W-1:0]                line;
    logic [COUNT_W-1:0]               clue_cnt;
    logic [COUNT_W-1:0]               clue_idx;
    logic [MAX_CLUES-1:0][CLUE_W-1:0] clue_buf;
    logic                             done_pend;
`ifdef CLUE_SUM_CHECK_EN
    logic [7:0]                       clue_sum;
    logic [7:0]                       sum_next;
`endif

    logic                             dim_ok;
    logic                             count_ok;
    logic                             clue_ok;
    logic                             sum_ok;
    logic                             last_clue;
    logic                             last_line;
    logic [CLUE_W-1:0]                line_len;
    logic [MAX_CLUES-1:0][CLUE_W-1:0] clue_ins;
    line_word_t                       emit_word;

    // Byte validation and the word that would be emitted on the final clue.
    always_comb begin
        dim_ok    = (axiid != 8'd0) && (axiid <= 8'(MAX_DIM));
        count_ok  = (axiid <= 8'(MAX_CLUES));
        line_len  = (CMP_W'(line) < CMP_W'(rows)) ? cols : rows;
        clue_ok   = (axiid != 8'd0) && (axiid <= 8'(line_len));
        last_clue = ((clue_idx + COUNT_W'(1)) == clue_cnt);
        last_line = (CMP_W'(line) == (CMP_W'(rows) + CMP_W'(cols) - CMP_W'(1)));
        clue_ins  = clue_buf;
        clue_ins[clue_idx[IDX_W-1:0]] = axiid[CLUE_W-1:0];
        emit_word.count = clue_cnt;
        emit_word.clue  = clue_ins;
`ifdef CLUE_SUM_CHECK_EN
        // Each clue after the first needs one blank separator cell.
        sum_next = clue_sum + axiid + 8'(clue_idx != COUNT_W'(0));
        sum_ok   = (sum_next <= 8'(line_len));
`else
        sum_ok   = 1'b1;
`endif
    end

    // Parser FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            line       <= '0;
            clue_cnt   <= '0;
            clue_idx   <= '0;
            clue_buf   <= '0;
            done_pend  <= 1'b0;
            axiov      <= 1'b0;
            axiod      <= '0;
            addr       <= '0;
            board_done <= 1'b0;
            rows       <= '0;
            cols       <= '0;
            err        <= 1'b0;
`ifdef CLUE_SUM_CHECK_EN
            clue_sum   <= '0;
`endif
        end else begin
            axiov      <= 1'b0;
            board_done <= done_pend;
            done_pend  <= 1'b0;
            case (state)
                IDLE: begin
                    if (axiiv) begin
                        if (dim_ok) begin
                            rows  <= axiid[CLUE_W-1:0];
                            state <= GET_COLS;
                        end else begin
                            err   <= 1'b1;
                            state <= ERROR;
                        end
                    end
                end
                GET_COLS: begin
                    if (axiiv) begin
                        if (dim_ok) begin
                            cols  <= axiid[CLUE_W-1:0];
                            line  <= '0;
                            state <= GET_COUNT;
                        end else begin
                            err   <= 1'b1;
                            state <= ERROR;
                        end
                    end
                end
                GET_COUNT: begin
                    if (axiiv) begin
                        clue_buf <= '0;
                        clue_idx <= '0;
                        clue_cnt <= axiid[COUNT_W-1:0];
`ifdef CLUE_SUM_CHECK_EN
                        clue_sum <= '0;
`endif
                        if (!count_ok) begin
                            err   <= 1'b1;
                            state <= ERROR;
                        end else if (axiid == 8'd0) begin
                            axiov <= 1'b1;
                            axiod <= '0;
                            addr  <= line;
                            line  <= line + ADDR_W'(1);
                            if (last_line) begin
                                done_pend <= 1'b1;
                                state     <= IDLE;
                            end
                        end else begin
                            state <= GET_CLUE;
                        end
                    end
                end
                GET_CLUE: begin
                    if (axiiv) begin
                        if (!clue_ok) begin
                            err   <= 1'b1;
                            state <= ERROR;
                        end else if (last_clue) begin
                            if (!sum_ok) begin
                                err   <= 1'b1;
                                state <= ERROR;
                            end else begin
                                axiov <= 1'b1;
                                axiod <= emit_word;
                                addr  <= line;
                                line  <= line + ADDR_W'(1);
                                if (last_line) begin
                                    done_pend <= 1'b1;
                                    state     <= IDLE;
                                end else begin
                                    state     <= GET_COUNT;
                                end
                            end
                        end else begin
                            clue_buf <= clue_ins;
                            clue_idx <= clue_idx + COUNT_W'(1);
`ifdef CLUE_SUM_CHECK_EN
                            clue_sum <= sum_next;
`endif
                        end
                    end
                end
                ERROR: begin
                    if (axiiv && (axiid == SYNC_BYTE)) begin
                        err   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clue_stream_parser.sv
// Scoreboard bench for clue_stream_parser: stimulus pushes expected words and
// board_done markers; a negedge monitor pops and compares them.
module tb_clue_stream_parser;
    import nonogram_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              axiiv = 1'b0;
    logic [7:0]        axiid = 8'd0;
    logic              axiov;
    logic [LINE_W-1:0] axiod;
    logic [ADDR_W-1:0] addr;
    logic              board_done;
    logic [CLUE_W-1:0] rows;
    logic [CLUE_W-1:0] cols;
    logic              err;

    clue_stream_parser dut (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
        .axiov(axiov), .axiod(axiod), .addr(addr), .board_done(board_done),
        .rows(rows), .cols(cols), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                is_done;
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] w;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc = 0;
    int   last_w_cyc = 0;
    int   done_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%h required=%h", nm, act, req);
    endtask

    // Word layout: {count, clue7 .. clue0}, clue0 in the LSBs.
    function automatic logic [LINE_W-1:0] mkw(input int k, input int c0 = 0, input int c1 = 0);
        logic [LINE_W-1:0] w;
        w = '0;
        w[LINE_W-1 -: COUNT_W] = COUNT_W'(k);
        w[0 +: CLUE_W]         = CLUE_W'(c0);
        w[CLUE_W +: CLUE_W]    = CLUE_W'(c1);
        return w;
    endfunction

    function automatic logic [LINE_W-1:0] mkw_all_ones();
        logic [LINE_W-1:0] w;
        w = '0;
        w[LINE_W-1 -: COUNT_W] = COUNT_W'(8);
        for (int i = 0; i < 8; i++) w[i*CLUE_W +: CLUE_W] = CLUE_W'(1);
        return w;
    endfunction

    task automatic expw(input int a, input logic [LINE_W-1:0] w);
        exp_t x;
        x.is_done = 1'b0; x.a = ADDR_W'(a); x.w = w;
        q.push_back(x);
    endtask

    task automatic expd();
        exp_t x;
        x.is_done = 1'b1; x.a = '0; x.w = '0;
        q.push_back(x);
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        axiiv = 1'b1; axiid = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            axiiv = 1'b0; axiid = 8'd0;
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: every presented output must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (board_done) begin
                done_cnt++;
                if (q.size() == 0 || !q[0].is_done) begin
                    n_total++;
                    $display("FAIL unexpected_board_done actual=1 required=0 cyc=%0d", cyc);
                end else begin
                    void'(q.pop_front());
                    chk("board_done_latency", 64'(cyc - last_w_cyc), 64'd1);
                end
            end
            if (axiov) begin
                if (q.size() == 0 || q[0].is_done) begin
                    n_total++;
                    $display("FAIL unexpected_axiov actual=1 required=0 addr=%0d word=%h", addr, axiod);
                end else begin
                    e = q.pop_front();
                    chk("addr", 64'(addr), 64'(e.a));
                    chk("word", 64'(axiod), 64'(e.w));
                    last_w_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int dc;
        // Reset state
        #2;
        chk("rst_axiov", 64'(axiov), 0);
        chk("rst_axiod", 64'(axiod), 0);
        chk("rst_addr", 64'(addr), 0);
        chk("rst_board_done", 64'(board_done), 0);
        chk("rst_rows", 64'(rows), 0);
        chk("rst_cols", 64'(cols), 0);
        chk("rst_err", 64'(err), 0);
        #10 rst = 1'b0;
        idle(2);

        // 2x2 board with a gap inside the stream
        expw(0, mkw(1, 2)); expw(1, mkw(1, 1));
        expw(2, mkw(1, 2)); expw(3, mkw(1, 1)); expd();
        send(8'h02); send(8'h02); send(8'h01); send(8'h02); send(8'h01);
        idle(2);
        send(8'h01); send(8'h01); send(8'h02); send(8'h01); send(8'h01);
        idle(3);
        chk("t1_rows", 64'(rows), 2);
        chk("t1_cols", 64'(cols), 2);
        chk("t1_err", 64'(err), 0);
        chk("t1_drained", 64'(q.size()), 0);

        // Zero-count lines, first and last
        expw(0, '0); expw(1, mkw(1, 1)); expd();
        send(8'h01); send(8'h01); send(8'h00); send(8'h01); send(8'h01);
        idle(3);
        expw(0, mkw(1, 1)); expw(1, mkw(1, 1)); expw(2, '0); expd();
        send(8'h02); send(8'h01); send(8'h01); send(8'h01); send(8'h01); send(8'h01); send(8'h00);
        idle(3);
        chk("t2_drained", 64'(q.size()), 0);

        // Clue longer than the line, junk ignored, sync recovers
        send(8'h02); send(8'h02); send(8'h01); send(8'h03);
        idle(2);
        chk("t3_err_set", 64'(err), 1);
        send(8'h01); send(8'h01); send(8'h02); send(8'h00);
        idle(2);
        chk("t3_err_sticky", 64'(err), 1);
        send(8'hFF);
        idle(2);
        chk("t3_err_cleared", 64'(err), 0);
        expw(0, mkw(1, 1)); expw(1, mkw(1, 1)); expd();
        send(8'h01); send(8'h01); send(8'h01); send(8'h01); send(8'h01); send(8'h01);
        idle(3);
        chk("t3_drained", 64'(q.size()), 0);

        // Boundary rejections: zero rows, 17 cols, count 9, zero clue
        send(8'h00); idle(2);
        chk("t3_rows_zero", 64'(err), 1);
        send(8'hFF); idle(1);
        send(8'h02); send(8'h11); idle(2);
        chk("t3_cols_17", 64'(err), 1);
        send(8'hFF); idle(1);
        send(8'h01); send(8'h01); send(8'h09); idle(2);
        chk("t3_count_9", 64'(err), 1);
        send(8'hFF); idle(1);
        send(8'h01); send(8'h01); send(8'h01); send(8'h00); idle(2);
        chk("t3_clue_zero", 64'(err), 1);
        send(8'hFF); idle(2);
        chk("t3_recovered", 64'(err), 0);

        // 3x3 with row 0 = 2 clues 2,1 (needs 4 cells)
`ifdef CLUE_SUM_CHECK_EN
        send(8'h03); send(8'h03); send(8'h02); send(8'h02); send(8'h01);
        idle(2);
        chk("t4_sum_err", 64'(err), 1);
        send(8'hFF); idle(2);
        chk("t4_sum_recovered", 64'(err), 0);
`else
        expw(0, mkw(2, 2, 1)); expw(1, mkw(1, 3)); expw(2, '0);
        expw(3, mkw(1, 1)); expw(4, mkw(1, 1)); expw(5, '0); expd();
        send(8'h03); send(8'h03); send(8'h02); send(8'h02); send(8'h01);
        send(8'h01); send(8'h03); send(8'h00);
        send(8'h01); send(8'h01); send(8'h01); send(8'h01); send(8'h00);
        idle(3);
        chk("t4_no_sum_err", 64'(err), 0);
`endif
        chk("t4_drained", 64'(q.size()), 0);

        // Async reset off the clock edge, while a word is being presented
        send(8'h02); send(8'h02); send(8'h01); send(8'h01);
        @(posedge clk); #1;
        axiiv = 1'b0;
        chk("t5_pre_axiov", 64'(axiov), 1);
        chk("t5_pre_word", 64'(axiod), 64'(mkw(1, 1)));
        #1 rst = 1'b1;
        #1;
        chk("t5_axiov", 64'(axiov), 0);
        chk("t5_axiod", 64'(axiod), 0);
        chk("t5_rows", 64'(rows), 0);
        chk("t5_cols", 64'(cols), 0);
        chk("t5_err", 64'(err), 0);
        #3 rst = 1'b0;
        idle(1);
        // Reset again in the middle of a multi-clue line
        send(8'h03); send(8'h03); send(8'h02); send(8'h01);
        @(posedge clk); #1;
        axiiv = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t5_mid_clue_rows", 64'(rows), 0);
        chk("t5_mid_clue_axiov", 64'(axiov), 0);
        #4 rst = 1'b0;
        idle(1);
        expw(0, mkw(1, 1)); expw(1, mkw(1, 1)); expd();
        send(8'h01); send(8'h01); send(8'h01); send(8'h01); send(8'h01); send(8'h01);
        idle(3);
        chk("t5_drained", 64'(q.size()), 0);

        // 16x16 back to back, then a 1x1 header during board_done
        dc = done_cnt;
        for (int i = 0; i < 32; i++) begin
            case (i % 4)
                0: expw(i, '0);
                1: expw(i, mkw(1, (i % 16) + 1));
                2: expw(i, mkw_all_ones());
                default: begin
                    e.is_done = 1'b0;
                    expw(i, mkw(2, 3, 12));
                end
            endcase
        end
        expd();
        expw(0, mkw(1, 1)); expw(1, mkw(1, 1)); expd();
        send(8'h10); send(8'h10);
        for (int i = 0; i < 32; i++) begin
            case (i % 4)
                0: send(8'h00);
                1: begin send(8'h01); send(8'((i % 16) + 1)); end
                2: begin
                    send(8'h08);
                    for (int j = 0; j < 8; j++) send(8'h01);
                end
                default: begin send(8'h02); send(8'h03); send(8'h0C); end
            endcase
        end
        send(8'h01); send(8'h01); send(8'h01); send(8'h01); send(8'h01); send(8'h01);
        idle(5);
        k = done_cnt - dc;
        chk("t6_done_pulses", 64'(k), 2);
        chk("t6_err", 64'(err), 0);
        chk("t6_rows", 64'(rows), 1);
        chk("t6_drained", 64'(q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
